// File: rtl/clint_responder_if.sv
// Core load/store bus as seen by the CLINT target: valid/ready handshake,
// address, write data with byte strobes, and registered read data.
interface clint_responder_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/clint_responder.sv
// Machine timer / software-interrupt block (CLINT subset) on the core bus.
// IRQ7 = registered (mtime >= mtimecmp), IRQ3 = msip[0].
module clint_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                clk,
    input  logic                resetn,
    clint_responder_if.slave    bus,
    output logic                IRQ3,
    output logic                IRQ7
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
    localparam logic [31:0] WIN_SIZE  = 32'h0000_C000;

    localparam logic [13:0] W_MSIP   = 14'h0000;
    localparam logic [13:0] W_CMP_LO = 14'h1000;
    localparam logic [13:0] W_CMP_HI = 14'h1001;
    localparam logic [13:0] W_MT_LO  = 14'h2FFE;
    localparam logic [13:0] W_MT_HI  = 14'h2FFF;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq7_q, irq7_d;

    logic [31:0] offset;
    logic [13:0] word;
    logic        sel;
    logic        access;
    logic        wr;
    logic        tick;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        offset = bus.mem_addr - BASE_ADDR;
        word   = offset[15:2];
        sel    = bus.mem_valid && (offset < WIN_SIZE);
        access = (state_q == IDLE) && sel;
        wr     = access && (bus.mem_wstrb != 4'b0000);
        tick   = (presc_q == PRESC_MAX);
    end

    always_comb begin
        rd_val = '0;
        case (word)
            W_MSIP:   rd_val = {31'b0, msip_q};
            W_CMP_LO: rd_val = mtimecmp_q[31:0];
            W_CMP_HI: rd_val = mtimecmp_q[63:32];
            W_MT_LO:  rd_val = mtime_q[31:0];
            W_MT_HI:  rd_val = mtime_q[63:32];
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = tick ? '0 : presc_q + 16'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = rdata_q;
        irq7_d     = (mtime_q >= mtimecmp_q);

        case (state_q)
            IDLE: begin
                if (sel) begin
                    state_d = ACK;
                    rdata_d = rd_val;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A write to either mtime half replaces that cycle's tick entirely.
        if (tick) mtime_d = mtime_q + 64'd1;

        if (wr) begin
            case (word)
                W_MSIP: begin
                    if (bus.mem_wstrb[0]) msip_d = bus.mem_wdata[0];
                end
                W_CMP_LO: mtimecmp_d[31:0] =
                    merge_bytes(mtimecmp_q[31:0], bus.mem_wdata, bus.mem_wstrb);
                W_CMP_HI: mtimecmp_d[63:32] =
                    merge_bytes(mtimecmp_q[63:32], bus.mem_wdata, bus.mem_wstrb);
                W_MT_LO: mtime_d = {mtime_q[63:32],
                    merge_bytes(mtime_q[31:0], bus.mem_wdata, bus.mem_wstrb)};
                W_MT_HI: mtime_d = {
                    merge_bytes(mtime_q[63:32], bus.mem_wdata, bus.mem_wstrb),
                    mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            irq7_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            irq7_q     <= irq7_d;
        end
    end

    assign bus.mem_ready = (state_q == ACK);
    assign bus.mem_rdata = rdata_q;
    assign IRQ3          = msip_q;
    assign IRQ7          = irq7_q;

endmodule

// File: tb/tb_clint_responder.sv
// Directed bench for clint_responder: register map, timer compare, carry/wrap,
// write/tick collision, decode window and reset during ACK.
module tb_clint_responder;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic IRQ3;
    logic IRQ7;

    clint_responder_if bus ();

    clint_responder #(
        .BASE_ADDR(BASE),
        .TICK_DIV (1)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus),
        .IRQ3  (IRQ3),
        .IRQ7  (IRQ7)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // mtime model: value held after edge mt_cyc, +1 per edge after that.
    logic [63:0] mt_val = '0;
    int          mt_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mt_at(input int k);
        return mt_val + 64'(k - mt_cyc);
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // acc = cycle number of the accepting edge, -1 if no ready within 10 edges.
    task automatic xfer(input logic [31:0] off, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit presync,
                        output logic [31:0] rdata, output int acc, output int lat);
        if (presync) begin
            @(posedge clk);
            #1;
        end
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + off;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        acc   = -1;
        lat   = 0;
        rdata = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_ready) begin
                acc   = cyc;
                rdata = bus.mem_rdata;
                break;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] rd;
        int          acc;
        int          lat;
        logic [63:0] pre;
        xfer(off, d, s, 1'b1, rd, acc, lat);
        check({tag, "_ack"}, 64'(acc >= 0), 64'd1);
        if (acc >= 0 && off == 32'hBFF8) begin
            pre    = mt_at(acc - 1);
            mt_val = {pre[63:32], merge32(pre[31:0], d, s)};
            mt_cyc = acc;
        end else if (acc >= 0 && off == 32'hBFFC) begin
            pre    = mt_at(acc - 1);
            mt_val = {merge32(pre[63:32], d, s), pre[31:0]};
            mt_cyc = acc;
        end
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data, output int acc);
        int lat;
        xfer(off, 32'h0, 4'b0000, 1'b1, data, acc, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          acc;
        int          lat;
        int          exp_rise;
        int          rise;
        logic [63:0] m;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'b0000;

        // reset values; request issued together with reset release
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq7", 64'(IRQ7), 64'd0);
        check("rst_irq3", 64'(IRQ3), 64'd0);
        check("rst_ready", 64'(bus.mem_ready), 64'd0);
        resetn = 1'b1;
        mt_val = '0;
        mt_cyc = cyc;
        xfer(32'hBFF8, 32'h0, 4'b0000, 1'b0, d, acc, lat);
        check("rst_latency", 64'(lat), 64'd1);
        check("rst_mtime_lo", 64'(d), 64'h0);
        rd(32'h4004, d, acc);
        check("rst_cmp_hi", 64'(d), 64'hFFFF_FFFF);
        check("rst_irq7_b", 64'(IRQ7), 64'd0);

        // software interrupt
        wr("msip_set", 32'h0000, 32'hFFFF_FFFF, 4'b0001);
        check("irq3_set", 64'(IRQ3), 64'd1);
        rd(32'h0000, d, acc);
        check("msip_read", 64'(d), 64'h1);
        wr("msip_clr", 32'h0000, 32'h0, 4'b1111);
        check("irq3_clr", 64'(IRQ3), 64'd0);

        // timer compare
        wr("cmp_hi", 32'h4004, 32'h0, 4'b1111);
        wr("mt_hi0", 32'hBFFC, 32'h0, 4'b1111);
        wr("mt_lo0", 32'hBFF8, 32'h0, 4'b1111);
        wr("cmp_lo20", 32'h4000, 32'd20, 4'b1111);
        check("irq7_before", 64'(IRQ7), 64'd0);
        exp_rise = mt_cyc + 20 - int'(mt_val[31:0]) + 1;
        rise = -1;
        for (int i = 0; i < 100; i++) begin
            if (IRQ7) begin
                rise = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("irq7_rise_cyc", 64'(rise), 64'(exp_rise));
        wr("cmp_lo_ones", 32'h4000, 32'hFFFF_FFFF, 4'b1111);
        check("irq7_hold", 64'(IRQ7), 64'd1);
        @(posedge clk);
        #1;
        check("irq7_clear", 64'(IRQ7), 64'd0);

        // carry from low into high word
        wr("carry_lo", 32'hBFF8, 32'hFFFF_FFFE, 4'b1111);
        wr("carry_hi", 32'hBFFC, 32'h0, 4'b1111);
        rd(32'hBFFC, d, acc);
        m = mt_at(acc - 1);
        check("carry_hi_rd", 64'(d), 64'(m[63:32]));
        check("carry_hi_one", 64'(d), 64'h1);
        rd(32'hBFF8, d, acc);
        m = mt_at(acc - 1);
        check("carry_lo_rd", 64'(d), 64'(m[31:0]));

        // 64-bit wrap
        wr("wrap_hi", 32'hBFFC, 32'hFFFF_FFFF, 4'b1111);
        wr("wrap_lo", 32'hBFF8, 32'hFFFF_FFFF, 4'b1111);
        rd(32'hBFFC, d, acc);
        m = mt_at(acc - 1);
        check("wrap_hi_rd", 64'(d), 64'(m[63:32]));
        check("wrap_hi_zero", 64'(d), 64'h0);
        rd(32'hBFF8, d, acc);
        m = mt_at(acc - 1);
        check("wrap_lo_rd", 64'(d), 64'(m[31:0]));

        // byte strobe write colliding with a tick
        wr("coll_wr", 32'hBFF8, 32'h00AB_0000, 4'b0100);
        rd(32'hBFF8, d, acc);
        m = mt_at(acc - 1);
        check("coll_lo_rd", 64'(d), 64'(m[31:0]));
        check("coll_byte2", 64'(d[23:16]), 64'hAB);
        rd(32'hBFFC, d, acc);
        m = mt_at(acc - 1);
        check("coll_hi_rd", 64'(d), 64'(m[63:32]));

        // decode window edges
        xfer(32'h0000_C000, 32'h0, 4'b0000, 1'b1, d, acc, lat);
        check("oob_noready", 64'(acc >= 0), 64'd0);
        xfer(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b1111, 1'b1, d, acc, lat);
        check("below_noready", 64'(acc >= 0), 64'd0);
        wr("hole_wr", 32'h8000, 32'hFFFF_FFFF, 4'b1111);
        rd(32'h8000, d, acc);
        check("hole_ack", 64'(acc >= 0), 64'd1);
        check("hole_rdata", 64'(d), 64'h0);

        // reset asserted during ACK
        wr("pre_msip", 32'h0000, 32'h1, 4'b0001);
        wr("pre_cmp_lo", 32'h4000, 32'h0, 4'b1111);
        wr("pre_cmp_hi", 32'h4004, 32'h0, 4'b1111);
        @(posedge clk);
        #1;
        check("pre_irq7", 64'(IRQ7), 64'd1);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'h0000_0000;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        check("ack_ready", 64'(bus.mem_ready), 64'd1);
        resetn = 1'b0;
        #1;
        check("arst_ready", 64'(bus.mem_ready), 64'd0);
        check("arst_rdata", 64'(bus.mem_rdata), 64'h0);
        check("arst_irq3", 64'(IRQ3), 64'd0);
        check("arst_irq7", 64'(IRQ7), 64'd0);
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mt_val = '0;
        mt_cyc = cyc;
        rd(32'h4000, d, acc);
        check("arst_cmp_lo", 64'(d), 64'hFFFF_FFFF);
        rd(32'h0000, d, acc);
        check("arst_msip", 64'(d), 64'h0);
        rd(32'hBFF8, d, acc);
        m = mt_at(acc - 1);
        check("arst_mtime_lo", 64'(d), 64'(m[31:0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
